// File: rtl/fifo_sync1.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sync1
//  Description : Single-clock FIFO with registered status flags, write/read
//                handshake pulses and a selectable read mode:
//                  FWFT = 0 : standard mode, rd_data registered one cycle
//                             after an accepted read, qualified by a
//                             one-cycle rd_valid pulse.
//                  FWFT = 1 : first-word-fall-through, head word is always
//                             presented on rd_data while rd_valid = !empty;
//                             rd_en acknowledges (pops) the head word.
//
//  Ports       : sys_clk      - clock, all logic on the rising edge
//                srst_n       - synchronous active-low reset
//                wr_en        - write request
//                wr_data      - write data word
//                full         - FIFO holds DEPTH words
//                almost_full  - data_cnt >= AF_LEVEL
//                wr_ack       - previous-cycle write was accepted
//                overflow     - previous-cycle write was rejected
//                rd_en        - read request / head-word acknowledge
//                rd_data      - read data word
//                rd_valid     - rd_data holds valid data
//                empty        - FIFO holds no words
//                almost_empty - data_cnt <= AE_LEVEL
//                underflow    - previous-cycle read was rejected
//                data_cnt     - number of stored words (0..DEPTH)
//
//  Parameters  : WIDTH_DATA (8), WIDTH_ADDR (4), FWFT (0),
//                AF_LEVEL (DEPTH-2, legal 1..DEPTH),
//                AE_LEVEL (2, legal 0..DEPTH-1)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync1 #(
    parameter int WIDTH_DATA = 8,
    parameter int WIDTH_ADDR = 4,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = (2 ** WIDTH_ADDR) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  sys_clk,
    input  logic                  srst_n,
    // write side
    input  logic                  wr_en,
    input  logic [WIDTH_DATA-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    output logic                  wr_ack,
    output logic                  overflow,
    // read side
    input  logic                  rd_en,
    output logic [WIDTH_DATA-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  underflow,
    // fill level
    output logic [WIDTH_ADDR:0]   data_cnt
);

    localparam int DEPTH = 2 ** WIDTH_ADDR;

    // Constants sized to the counter so flag compares are width-exact.
    localparam logic [WIDTH_ADDR:0]   c_depth    = (WIDTH_ADDR + 1)'(DEPTH);
    localparam logic [WIDTH_ADDR:0]   c_af_level = (WIDTH_ADDR + 1)'(AF_LEVEL);
    localparam logic [WIDTH_ADDR:0]   c_ae_level = (WIDTH_ADDR + 1)'(AE_LEVEL);
    localparam logic [WIDTH_ADDR-1:0] c_ptr_one  = WIDTH_ADDR'(1);
    localparam logic [WIDTH_ADDR:0]   c_cnt_zero = '0;

    // ------------------------------------------------------------------
    // Storage (not reset: contents are meaningless once the pointers and
    // count are cleared)
    // ------------------------------------------------------------------
    logic [WIDTH_DATA-1:0] r_mem [DEPTH];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH_ADDR-1:0] r_wr_ptr;
    logic [WIDTH_ADDR-1:0] r_rd_ptr;
    logic [WIDTH_ADDR:0]   r_cnt;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [WIDTH_ADDR-1:0] w_wr_ptr_nxt;
    logic [WIDTH_ADDR-1:0] w_rd_ptr_nxt;
    logic [WIDTH_ADDR:0]   w_cnt_nxt;
    logic                  w_full_nxt;
    logic                  w_empty_nxt;
    logic                  w_afull_nxt;
    logic                  w_aempty_nxt;

    always_comb begin
        // Acceptance is judged on the registered flags, so a full FIFO
        // rejects a write even when a read frees a slot in the same cycle,
        // and an empty FIFO rejects a read even when a write arrives.
        w_wr_acc = wr_en & ~r_full;
        w_rd_acc = rd_en & ~r_empty;

        // Power-of-two depth: pointers wrap naturally on overflow.
        w_wr_ptr_nxt = w_wr_acc ? (r_wr_ptr + c_ptr_one) : r_wr_ptr;
        w_rd_ptr_nxt = w_rd_acc ? (r_rd_ptr + c_ptr_one) : r_rd_ptr;

        w_cnt_nxt = r_cnt
                  + {{WIDTH_ADDR{1'b0}}, w_wr_acc}
                  - {{WIDTH_ADDR{1'b0}}, w_rd_acc};

        // Flags derive from the next count so they are exact the cycle
        // after the causing edge.
        w_full_nxt   = (w_cnt_nxt == c_depth);
        w_empty_nxt  = (w_cnt_nxt == c_cnt_zero);
        w_afull_nxt  = (w_cnt_nxt >= c_af_level);
        w_aempty_nxt = (w_cnt_nxt <= c_ae_level);
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (!srst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_full      <= w_full_nxt;
            r_empty     <= w_empty_nxt;
            r_afull     <= w_afull_nxt;
            r_aempty    <= w_aempty_nxt;
            r_wr_ack    <= w_wr_acc;
            r_overflow  <= wr_en & r_full;
            r_underflow <= rd_en & r_empty;
        end
    end

    // ------------------------------------------------------------------
    // Memory write; gated by reset so requests in a reset cycle are dropped
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (srst_n && w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Read-side presentation
    // ------------------------------------------------------------------
    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always visible; it is valid whenever the FIFO
            // is non-empty. A word written into an empty FIFO shows up one
            // cycle after its write edge, when empty drops.
            assign rd_data  = r_mem[r_rd_ptr];
            assign rd_valid = ~r_empty;
        end else begin : g_std
            logic [WIDTH_DATA-1:0] r_rd_data;
            logic                  r_rd_valid;

            always_ff @(posedge sys_clk) begin
                if (!srst_n) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    // rd_data holds its last value between reads.
                    if (w_rd_acc) begin
                        r_rd_data <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign rd_data  = r_rd_data;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign full         = r_full;
    assign almost_full  = r_afull;
    assign wr_ack       = r_wr_ack;
    assign overflow     = r_overflow;
    assign empty        = r_empty;
    assign almost_empty = r_aempty;
    assign underflow    = r_underflow;
    assign data_cnt     = r_cnt;

endmodule
`default_nettype wire
